mdu_sequencer: RTL and testbench
================================

MDU_SEQUENCER -- requirements
Module: mdu_sequencer

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 4, giving the number of datapath step cycles per multiply (legal range 1..63).
REQ-002 SHALL have parameter DIV_CYCLES, default 32, giving the number of datapath step cycles per divide/remainder (legal range 1..63).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port mul_en, input, 1 bit: decoder multiply request.
REQ-006 SHALL have port mul_operation, input, 1 bit: decoder multiply variant (0 = low word, 1 = high word).
REQ-007 SHALL have port div_en, input, 1 bit: decoder divide request.
REQ-008 SHALL have port div_operation, input, 1 bit: decoder divide variant (0 = quotient, 1 = remainder).
REQ-009 SHALL have port write_sel, input, 5 bits: destination register of the requesting instruction.
REQ-010 SHALL have port divisor_zero, input, 1 bit: rs2 operand equals zero.
REQ-011 SHALL have port flush, input, 1 bit: pipeline flush from branch/JALR redirect.
REQ-012 SHALL have port stall, output, 1 bit: freeze fetch and decode.
REQ-013 SHALL have port dp_start, output, 1 bit: load operands into the mul/div datapath.
REQ-014 SHALL have port dp_step, output, 1 bit: advance the iterative datapath by one step.
REQ-015 SHALL have port dp_op, output, 2 bits: {is_div, variant}, stable from dp_start until wb_valid.
REQ-016 SHALL have port wb_valid, output, 1 bit: one-cycle pulse; datapath result is ready for write-back.
REQ-017 SHALL have port wb_sel, output, 5 bits: latched destination register, valid while wb_valid is high.
REQ-018 SHALL have port dz_bypass, output, 1 bit: accompanies wb_valid when the result is the divide-by-zero constant.

Function
REQ-019 SHALL implement the states IDLE, BUSY and DONE.
REQ-020 In IDLE with (mul_en | div_en) & ~flush, the block SHALL accept the request: latch dp_op and wb_sel, load count = N-1 (N = MUL_CYCLES or DIV_CYCLES), and go to BUSY.
REQ-021 When mul_en and div_en are both high, mul_en SHALL take priority and div_en SHALL be ignored.
REQ-022 stall SHALL be combinational: high in IDLE while a request is present and flush is low, and high throughout BUSY.
REQ-023 stall SHALL be low in DONE.
REQ-024 dp_start SHALL be high only in the first BUSY cycle; dp_step SHALL be high in every BUSY cycle.
REQ-025 In BUSY, count SHALL decrement each cycle; at count = 0 the block SHALL go to DONE.
REQ-026 The total is exactly N dp_step cycles, and stall is high for N+1 cycles.
REQ-027 DONE SHALL assert wb_valid for exactly one cycle, ignore mul_en/div_en, and go to IDLE.
REQ-028 A flush in BUSY SHALL return the block to IDLE on the next edge, with no wb_valid and with dp_step low from that edge on.
REQ-029 A flush in DONE SHALL NOT suppress wb_valid.
REQ-030 count SHALL be 6 bits wide and SHALL never wrap below 0.

Reset
REQ-031 While rst is high, the block SHALL be in IDLE with count = 0, dp_op = 0, wb_sel = 0, and stall, dp_start, dp_step, wb_valid and dz_bypass all 0.
REQ-032 Reset asserted mid-operation SHALL abort immediately, with no wb_valid after release.

Configuration
REQ-033 With MDU_DIVZERO_BYPASS_EN defined, a divide accepted with divisor_zero = 1 SHALL skip BUSY and go straight to DONE, with no dp_start or dp_step, stall high for 1 cycle, and dz_bypass = 1 alongside wb_valid.
REQ-034 Without MDU_DIVZERO_BYPASS_EN, divisor_zero SHALL be ignored, every divide SHALL take DIV_CYCLES steps, and dz_bypass SHALL be tied to 0.

Verification
REQ-035 mul_en=1, mul_operation=0, write_sel=5, default parameters -> stall high for 5 cycles, dp_start in cycle 2, 4 dp_step pulses, wb_valid with wb_sel=5 in cycle 6.
REQ-036 div_en=1, div_operation=1, write_sel=7, divisor_zero=0 -> 32 dp_step pulses, dp_op=2'b11 throughout, single wb_valid with wb_sel=7.
REQ-037 div_en=1, divisor_zero=1, macro defined -> wb_valid and dz_bypass in the cycle after accept, dp_step never high; macro undefined -> 32 steps and dz_bypass=0.
REQ-038 mul_en and div_en both high -> dp_op=2'b00 or 2'b01 per mul_operation, MUL_CYCLES steps only.
REQ-039 flush pulsed in the 3rd BUSY cycle of a divide -> IDLE next cycle, no wb_valid, stall low; a new mul request is then accepted normally.
REQ-040 rst asserted asynchronously mid-divide -> all outputs 0 immediately, no wb_valid after release.

Source files
------------

// File: rtl/mdu_sequencer.sv
// Multiply/divide sequencer: stalls the pipeline while the iterative mul/div datapath runs, then requests write-back.
// Optional divide-by-zero shortcut enabled by defining MDU_DIVZERO_BYPASS_EN.
module mdu_sequencer #(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mul_en,
    input  logic       mul_operation,
    input  logic       div_en,
    input  logic       div_operation,
    input  logic [4:0] write_sel,
    input  logic       divisor_zero,
    input  logic       flush,
    output logic       stall,
    output logic       dp_start,
    output logic       dp_step,
    output logic [1:0] dp_op,
    output logic       wb_valid,
    output logic [4:0] wb_sel,
    output logic       dz_bypass
);

    localparam int unsigned CNT_W = 6;
    localparam int unsigned SEL_W = 5;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   count;
    logic               first;
    logic [1:0]         op_q;
    logic [SEL_W-1:0]   sel_q;
    logic               dz_q;

    logic               req;
    logic               accept;
    logic               is_div;
    logic               variant;
    logic               bypass;

    // Multiply wins when both decoder requests are present.
    assign req     = mul_en | div_en;
    assign accept  = (state == IDLE) & req & ~flush;
    assign is_div  = ~mul_en & div_en;
    assign variant = mul_en ? mul_operation : div_operation;

`ifdef MDU_DIVZERO_BYPASS_EN
    assign bypass = accept & is_div & divisor_zero;
`else
    logic unused_divisor_zero;
    assign unused_divisor_zero = divisor_zero;
    assign bypass = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = bypass ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (flush) begin
                    state_next = IDLE;
                end else if (count == '0) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operation context latched at accept; step counter saturates at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            first <= 1'b0;
            op_q  <= '0;
            sel_q <= '0;
            dz_q  <= 1'b0;
        end else if (accept) begin
            count <= bypass ? '0 : (is_div ? DIV_LOAD : MUL_LOAD);
            first <= 1'b1;
            op_q  <= {is_div, variant};
            sel_q <= write_sel;
            dz_q  <= bypass;
        end else if (state == BUSY) begin
            first <= 1'b0;
            if (count != '0) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Output decode; stall is gated by rst so reset forces every output low.
    always_comb begin
        stall     = 1'b0;
        dp_start  = 1'b0;
        dp_step   = 1'b0;
        wb_valid  = 1'b0;
        dz_bypass = 1'b0;
        dp_op     = op_q;
        wb_sel    = sel_q;
        case (state)
            IDLE: begin
                stall = req & ~flush & ~rst;
            end
            BUSY: begin
                stall    = 1'b1;
                dp_start = first;
                dp_step  = 1'b1;
            end
            DONE: begin
                wb_valid  = 1'b1;
                dz_bypass = dz_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: vector table of single operations plus flush/reset corner sequences.
module tb_mdu_sequencer;

    localparam int unsigned MC = 4;
    localparam int unsigned DC = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       mul_en = 1'b0;
    logic       mul_operation = 1'b0;
    logic       div_en = 1'b0;
    logic       div_operation = 1'b0;
    logic [4:0] write_sel = '0;
    logic       divisor_zero = 1'b0;
    logic       flush = 1'b0;
    logic       stall;
    logic       dp_start;
    logic       dp_step;
    logic [1:0] dp_op;
    logic       wb_valid;
    logic [4:0] wb_sel;
    logic       dz_bypass;

    int checks = 0;
    int fails  = 0;

    mdu_sequencer #(.MUL_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .rst(rst),
        .mul_en(mul_en), .mul_operation(mul_operation),
        .div_en(div_en), .div_operation(div_operation),
        .write_sel(write_sel), .divisor_zero(divisor_zero), .flush(flush),
        .stall(stall), .dp_start(dp_start), .dp_step(dp_step), .dp_op(dp_op),
        .wb_valid(wb_valid), .wb_sel(wb_sel), .dz_bypass(dz_bypass)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       m_en;
        logic       m_op;
        logic       d_en;
        logic       d_op;
        logic [4:0] ws;
        logic       dz;
        logic [1:0] e_op;
        int         e_steps;
        logic       e_dz;
        string      name;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        mul_en = 1'b0; mul_operation = 1'b0; div_en = 1'b0; div_operation = 1'b0;
        write_sel = '0; divisor_zero = 1'b0; flush = 1'b0;
    endtask

    // Issue one request and profile outputs over a fixed 40-cycle window (cycle 1 = request cycle).
    task automatic run_op(input vec_t v);
        int stall_n = 0, step_n = 0, start_n = 0, start_cyc = 0;
        int wb_n = 0, wb_cyc = 0, dz_n = 0, op_bad = 0;
        logic [4:0] sel = '0;
        @(posedge clk); #1;
        mul_en = v.m_en; mul_operation = v.m_op; div_en = v.d_en; div_operation = v.d_op;
        write_sel = v.ws; divisor_zero = v.dz;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (stall) stall_n++;
            if (dp_step) begin
                step_n++;
                if (dp_op !== v.e_op) op_bad++;
            end
            if (dp_start) begin
                start_n++;
                start_cyc = c;
            end
            if (wb_valid) begin
                wb_n++;
                wb_cyc = c;
                sel = wb_sel;
                if (dp_op !== v.e_op) op_bad++;
            end
            if (dz_bypass) dz_n++;
            @(posedge clk); #1;
            clear_inputs();
        end
        check({v.name, " stall_cycles"}, 32'(stall_n), 32'(v.e_steps + 1));
        check({v.name, " step_count"}, 32'(step_n), 32'(v.e_steps));
        check({v.name, " start_count"}, 32'(start_n), (v.e_steps > 0) ? 32'd1 : 32'd0);
        check({v.name, " start_cycle"}, 32'(start_cyc), (v.e_steps > 0) ? 32'd2 : 32'd0);
        check({v.name, " wb_count"}, 32'(wb_n), 32'd1);
        check({v.name, " wb_cycle"}, 32'(wb_cyc), 32'(v.e_steps + 2));
        check({v.name, " wb_sel"}, 32'(sel), 32'(v.ws));
        check({v.name, " dz_bypass"}, 32'(dz_n), 32'(v.e_dz));
        check({v.name, " dp_op_stable"}, 32'(op_bad), 32'd0);
    endtask

    // Count activity over a window where the block must stay quiet.
    task automatic quiet_window(input string name, input int cycles);
        int stall_n = 0, step_n = 0, wb_n = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (stall) stall_n++;
            if (dp_step) step_n++;
            if (wb_valid) wb_n++;
        end
        check({name, " stall_cycles"}, 32'(stall_n), 32'd0);
        check({name, " step_count"}, 32'(step_n), 32'd0);
        check({name, " wb_count"}, 32'(wb_n), 32'd0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, " stall"}, 32'(stall), 32'd0);
        check({name, " dp_start"}, 32'(dp_start), 32'd0);
        check({name, " dp_step"}, 32'(dp_step), 32'd0);
        check({name, " dp_op"}, 32'(dp_op), 32'd0);
        check({name, " wb_valid"}, 32'(wb_valid), 32'd0);
        check({name, " wb_sel"}, 32'(wb_sel), 32'd0);
        check({name, " dz_bypass"}, 32'(dz_bypass), 32'd0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 5'd5,  1'b0, 2'b00, MC, 1'b0, "mul_lo"};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 5'd12, 1'b0, 2'b01, MC, 1'b0, "mul_hi"};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 5'd7,  1'b0, 2'b11, DC, 1'b0, "div_rem"};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 5'd31, 1'b0, 2'b10, DC, 1'b0, "div_quo"};
`ifdef MDU_DIVZERO_BYPASS_EN
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 5'd9,  1'b1, 2'b10, 0,  1'b1, "div_by_zero"};
`else
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 5'd9,  1'b1, 2'b10, DC, 1'b0, "div_by_zero"};
`endif
        vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 5'd3,  1'b0, 2'b01, MC, 1'b0, "both_mul_hi"};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 5'd0,  1'b1, 2'b00, MC, 1'b0, "both_mul_lo"};

        // Reset with a pending request: everything must read zero.
        #1 rst = 1'b1;
        mul_en = 1'b1; write_sel = 5'd17;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        clear_inputs();
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) run_op(vecs[i]);

        // Flush in the third BUSY cycle of a divide.
        @(posedge clk); #1;
        div_en = 1'b1; write_sel = 5'd10;
        @(posedge clk); #1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        check("flush_busy step_in_flush_cycle", 32'(dp_step), 32'd1);
        @(posedge clk); #1;
        flush = 1'b0;
        quiet_window("flush_busy", 40);
        run_op(vecs[0]);

        // Flush together with a request in IDLE: not accepted.
        @(posedge clk); #1;
        mul_en = 1'b1; flush = 1'b1;
        @(negedge clk);
        check("flush_idle stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        clear_inputs();
        quiet_window("flush_idle", 10);

        // Flush in DONE still delivers the write-back.
        @(posedge clk); #1;
        mul_en = 1'b1; write_sel = 5'd21;
        @(posedge clk); #1;
        clear_inputs();
        repeat (MC) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        check("flush_done wb_valid", 32'(wb_valid), 32'd1);
        check("flush_done wb_sel", 32'(wb_sel), 32'd21);
        check("flush_done stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_done wb_one_pulse", 32'(wb_valid), 32'd0);

        // Asynchronous reset mid-divide.
        repeat (4) @(posedge clk);
        #1 div_en = 1'b1; div_operation = 1'b1; write_sel = 5'd14;
        @(posedge clk); #1;
        clear_inputs();
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("async_rst busy_before", 32'(dp_step), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        quiet_window("async_rst_after", 40);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
